// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcode encodings and the
// transaction FSM state type.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/ALU.sv
// Purely combinational N-bit ALU: eight operations with carry/borrow/
// shifted-out flag and zero flag.
import alu_pkg::*;

module ALU #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] y,
    output logic         cf,
    output logic         zf
);

    logic [N:0] wide_s;

    // Operation decode; ADD/SUB take CF from the extra (N+1)th bit.
    always_comb begin
        wide_s = {(N+1){1'b0}};
        y      = {N{1'b0}};
        cf     = 1'b0;
        case (op)
            OP_ADD: begin
                wide_s = {1'b0, a} + {1'b0, b};
                y      = wide_s[N-1:0];
                cf     = wide_s[N];
            end
            OP_SUB: begin
                wide_s = {1'b0, a} - {1'b0, b};
                y      = wide_s[N-1:0];
                cf     = wide_s[N];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y  = {a[N-2:0], 1'b0};
                cf = a[N-1];
            end
            OP_SHR: begin
                y  = {1'b0, a[N-1:1]};
                cf = a[0];
            end
            default: begin
                y  = {N{1'b0}};
                cf = 1'b0;
            end
        endcase
        zf = (y == {N{1'b0}});
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters;
// one transaction at a time: IDLE -> EXEC -> RESP -> IDLE.
import alu_pkg::*;

module alu_rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_y,
    output logic         rsp_cf,
    output logic         rsp_zf,
    output logic         busy
);

    state_t       state_r;
    state_t       next_state_s;
    logic         last_grant_r;
    logic         grant_s;
    logic         hs_s;
    logic [N-1:0] opa_r;
    logic [N-1:0] opb_r;
    logic [2:0]   opc_r;
    logic         opid_r;
    logic [N-1:0] alu_y_s;
    logic         alu_cf_s;
    logic         alu_zf_s;

    ALU #(.N(N)) u_alu (
        .a  (opa_r),
        .b  (opb_r),
        .op (opc_r),
        .y  (alu_y_s),
        .cf (alu_cf_s),
        .zf (alu_zf_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: next_state_s = RESP;
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Grant and handshake outputs; on contention the last winner yields.
    always_comb begin
        grant_s = last_grant_r;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req0_valid) begin
            grant_s = 1'b0;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = last_grant_r;
        end
        req0_ready = (state_r == IDLE) && req0_valid && (grant_s == 1'b0);
        req1_ready = (state_r == IDLE) && req1_valid && (grant_s == 1'b1);
        hs_s       = req0_ready || req1_ready;
        busy       = (state_r != IDLE);
    end

    // Operand capture on handshake and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            opa_r        <= {N{1'b0}};
            opb_r        <= {N{1'b0}};
            opc_r        <= 3'b000;
            opid_r       <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_y        <= {N{1'b0}};
            rsp_cf       <= 1'b0;
            rsp_zf       <= 1'b0;
        end else begin
            if (hs_s) begin
                last_grant_r <= grant_s;
                opid_r       <= grant_s;
                opa_r        <= grant_s ? req1_a  : req0_a;
                opb_r        <= grant_s ? req1_b  : req0_b;
                opc_r        <= grant_s ? req1_op : req0_op;
            end
            if (state_r == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= opid_r;
                rsp_y     <= alu_y_s;
                rsp_cf    <= alu_cf_s;
                rsp_zf    <= alu_zf_s;
            end else if ((state_r == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: directed requests push expected
// responses; a negedge monitor pops and compares every accepted response.
module tb_alu_rr_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] y;
        logic       cf;
        logic       zf;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cf, rsp_zf, busy;
    logic [7:0] rsp_y;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    alu_rr_arbiter #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a handshake; returns one step after the accepting edge.
    task automatic wait_hs(output logic id, output logic ok);
        id = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_valid && req0_ready) begin
                id = 1'b0; ok = 1'b1; tick(); return;
            end else if (req1_valid && req1_ready) begin
                id = 1'b1; ok = 1'b1; tick(); return;
            end
            tick();
        end
    endtask

    task automatic drain;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: compare each response at the cycle it is accepted.
    initial begin
        rsp_t got, e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                got = {rsp_id, rsp_y, rsp_cf, rsp_zf};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_rsp: got id=%0d y=%0h cf=%0d zf=%0d expected none",
                             got.id, got.y, got.cf, got.zf);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_mis++;
                        $display("FAIL rsp: got id=%0d y=%0h cf=%0d zf=%0d expected id=%0d y=%0h cf=%0d zf=%0d",
                                 got.id, got.y, got.cf, got.zf, e.id, e.y, e.cf, e.zf);
                    end
                end
            end
        end
    end

    initial begin
        logic       id, ok;
        time        t_prev, t_now;
        logic [10:0] snap;
        rsp_t       sweep_exp [8];

        sweep_exp[0] = '{1'b1, 8'h00, 1'b1, 1'b1};
        sweep_exp[1] = '{1'b1, 8'h02, 1'b1, 1'b0};
        sweep_exp[2] = '{1'b1, 8'h01, 1'b0, 1'b0};
        sweep_exp[3] = '{1'b1, 8'hFF, 1'b0, 1'b0};
        sweep_exp[4] = '{1'b1, 8'hFE, 1'b0, 1'b0};
        sweep_exp[5] = '{1'b1, 8'hFE, 1'b0, 1'b0};
        sweep_exp[6] = '{1'b1, 8'h02, 1'b0, 1'b0};
        sweep_exp[7] = '{1'b1, 8'h00, 1'b1, 1'b1};

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_op = 3'b000;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 3'b000;
        rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_fields", {rsp_id, rsp_y, rsp_cf, rsp_zf}, 0);
        req0_valid = 1'b1;
        #1;
        check("rst_req0_ready", req0_ready, 1);
        req0_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single request, latency
        req0_a = 8'hF0; req0_b = 8'h20; req0_op = 3'b000; req0_valid = 1'b1;
        exp_q.push_back('{1'b0, 8'h10, 1'b1, 1'b0});
        wait_hs(id, ok);
        req0_valid = 1'b0;
        check("t1_hs_ok", ok, 1);
        check("t1_id", id, 0);
        check("t1_exec_rsp_valid", rsp_valid, 0);
        check("t1_exec_busy", busy, 1);
        tick();
        check("t1_rsp_valid_lat2", rsp_valid, 1);
        tick();
        check("t1_idle_busy", busy, 0);
        drain();

        // Contention, fresh reset so requester 0 wins first
        rst = 1'b1; tick(); rst = 1'b0;
        req0_a = 8'h05; req0_b = 8'h05; req0_op = 3'b001;
        req1_a = 8'h81; req1_b = 8'h00; req1_op = 3'b110;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_q.push_back('{1'b0, 8'h00, 1'b0, 1'b1});
            else            exp_q.push_back('{1'b1, 8'h02, 1'b1, 1'b0});
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_hs(id, ok);
            t_now = $time;
            check("t2_hs_ok", ok, 1);
            check("t2_order", id, i % 2);
            if (i > 0) check("t2_hs_spacing", t_now - t_prev, 30);
            t_prev = t_now;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Backpressure
        rsp_ready = 1'b0;
        req0_a = 8'h0F; req0_b = 8'h30; req0_op = 3'b011;
        req1_a = 8'h11; req1_b = 8'h22; req1_op = 3'b000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_q.push_back('{1'b0, 8'h3F, 1'b0, 1'b0});
        wait_hs(id, ok);
        check("t3_hs_ok", ok, 1);
        check("t3_id", id, 0);
        tick();
        snap = {rsp_id, rsp_y, rsp_cf, rsp_zf};
        for (int i = 0; i < 5; i++) begin
            check("t3_valid_held", rsp_valid, 1);
            check("t3_rsp_stable", {rsp_id, rsp_y, rsp_cf, rsp_zf}, snap);
            check("t3_readies_low", {req0_ready, req1_ready}, 0);
            check("t3_busy", busy, 1);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("t3_after_busy", busy, 0);
        check("t3_after_valid", rsp_valid, 0);
        drain();

        // Reset during EXEC drops the transaction
        req1_a = 8'h01; req1_b = 8'h01; req1_op = 3'b000; req1_valid = 1'b1;
        wait_hs(id, ok);
        check("t4_hs_ok", ok, 1);
        check("t4_id", id, 1);
        req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t4_busy_now", busy, 0);
        check("t4_rsp_valid_now", rsp_valid, 0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_no_rsp", rsp_valid, 0);
        end
        req0_a = 8'hFF; req0_b = 8'h3C; req0_op = 3'b010;
        req1_a = 8'hAA; req1_b = 8'h55; req1_op = 3'b100;
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_q.push_back('{1'b0, 8'h3C, 1'b0, 1'b0});
        wait_hs(id, ok);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t4_hs_ok", ok, 1);
        check("t4_post_rst_grant", id, 0);
        drain();

        // Opcode sweep on requester 1
        req1_a = 8'h01; req1_b = 8'hFF;
        for (int op = 0; op < 8; op++) begin
            req1_op = op[2:0];
            exp_q.push_back(sweep_exp[op]);
            req1_valid = 1'b1;
            wait_hs(id, ok);
            req1_valid = 1'b0;
            check("t5_hs_ok", ok, 1);
            check("t5_id", id, 1);
            tick();
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
